// File: rtl/wb_except_unit.sv
// wb_except_unit: writeback register and exception commit point (interrupt > exception > eret > write)
module wb_except_unit #(
    parameter logic [31:0] EX_ENTRY   = 32'hbfc0_0380,
    parameter logic [4:0]  INT_EXCODE = 5'h00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_to_ws_valid,
    output logic         ws_allowin,
    input  logic [31:0]  ms_pc,
    input  logic         ms_ex,
    input  logic [4:0]   ms_excode,
    input  logic [31:0]  ms_badvaddr,
    input  logic         ms_bd,
    input  logic         ms_mtc0,
    input  logic         ms_mfc0,
    input  logic         ms_eret,
    input  logic [4:0]   ms_c0_addr,
    input  logic [31:0]  ms_c0_wdata,
    input  logic         ms_gr_we,
    input  logic [4:0]   ms_dest,
    input  logic [31:0]  ms_result,
    input  logic [31:0]  c0_status,
    input  logic [31:0]  c0_cause,
    input  logic [31:0]  c0_epc,
    input  logic [31:0]  c0_rdata,
    output logic [4:0]   c0_raddr,
    output logic [109:0] wb_to_cp0_register_bus,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [31:0]  rf_wdata,
    output logic         ws_flush,
    output logic [31:0]  ws_flush_pc
);
    logic        ws_valid_q, ws_valid_d;
    logic [31:0] ws_pc_q, ws_pc_d;
    logic        ws_ex_q, ws_ex_d;
    logic [4:0]  ws_excode_q, ws_excode_d;
    logic [31:0] ws_badvaddr_q, ws_badvaddr_d;
    logic        ws_bd_q, ws_bd_d;
    logic        ws_mtc0_q, ws_mtc0_d;
    logic        ws_mfc0_q, ws_mfc0_d;
    logic        ws_eret_q, ws_eret_d;
    logic [4:0]  ws_c0_addr_q, ws_c0_addr_d;
    logic [31:0] ws_c0_wdata_q, ws_c0_wdata_d;
    logic        ws_gr_we_q, ws_gr_we_d;
    logic [4:0]  ws_dest_q, ws_dest_d;
    logic [31:0] ws_result_q, ws_result_d;
    logic        int_pend_q, int_pend_d;
    logic        ws_ready_go, load, int_raw, ex_int, ex_final, mtc0_we, eret_flush;
    logic [4:0]  bus_excode;
    logic [31:0] bus_badvaddr;
    logic        unused_c0;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;
    assign unused_c0   = ^{c0_status[31:16], c0_status[7:2], c0_cause[31:16], c0_cause[7:0]};

    // next WB contents: latch on accept, drop anything arriving in the flush cycle
    always_comb begin
        load          = ws_allowin && ms_to_ws_valid && !ws_flush;
        ws_valid_d    = load;
        ws_pc_d       = load ? ms_pc       : ws_pc_q;
        ws_ex_d       = load ? ms_ex       : ws_ex_q;
        ws_excode_d   = load ? ms_excode   : ws_excode_q;
        ws_badvaddr_d = load ? ms_badvaddr : ws_badvaddr_q;
        ws_bd_d       = load ? ms_bd       : ws_bd_q;
        ws_mtc0_d     = load ? ms_mtc0     : ws_mtc0_q;
        ws_mfc0_d     = load ? ms_mfc0     : ws_mfc0_q;
        ws_eret_d     = load ? ms_eret     : ws_eret_q;
        ws_c0_addr_d  = load ? ms_c0_addr  : ws_c0_addr_q;
        ws_c0_wdata_d = load ? ms_c0_wdata : ws_c0_wdata_q;
        ws_gr_we_d    = load ? ms_gr_we    : ws_gr_we_q;
        ws_dest_d     = load ? ms_dest     : ws_dest_q;
        ws_result_d   = load ? ms_result   : ws_result_q;
        int_raw       = c0_status[0] & ~c0_status[1] & |(c0_cause[15:8] & c0_status[15:8]);
        int_pend_d    = int_raw;
    end

    // WB state and interrupt-pending stage
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q    <= 1'b0;
            ws_pc_q       <= '0;
            ws_ex_q       <= 1'b0;
            ws_excode_q   <= '0;
            ws_badvaddr_q <= '0;
            ws_bd_q       <= 1'b0;
            ws_mtc0_q     <= 1'b0;
            ws_mfc0_q     <= 1'b0;
            ws_eret_q     <= 1'b0;
            ws_c0_addr_q  <= '0;
            ws_c0_wdata_q <= '0;
            ws_gr_we_q    <= 1'b0;
            ws_dest_q     <= '0;
            ws_result_q   <= '0;
            int_pend_q    <= 1'b0;
        end else begin
            ws_valid_q    <= ws_valid_d;
            ws_pc_q       <= ws_pc_d;
            ws_ex_q       <= ws_ex_d;
            ws_excode_q   <= ws_excode_d;
            ws_badvaddr_q <= ws_badvaddr_d;
            ws_bd_q       <= ws_bd_d;
            ws_mtc0_q     <= ws_mtc0_d;
            ws_mfc0_q     <= ws_mfc0_d;
            ws_eret_q     <= ws_eret_d;
            ws_c0_addr_q  <= ws_c0_addr_d;
            ws_c0_wdata_q <= ws_c0_wdata_d;
            ws_gr_we_q    <= ws_gr_we_d;
            ws_dest_q     <= ws_dest_d;
            ws_result_q   <= ws_result_d;
            int_pend_q    <= int_pend_d;
        end
    end

    // commit: exactly one outcome per WB instruction
    always_comb begin
        ex_int       = ws_valid_q & int_pend_q;
        ex_final     = ex_int | (ws_valid_q & ws_ex_q);
        mtc0_we      = ws_valid_q & ws_mtc0_q & ~ex_final;
        eret_flush   = ws_valid_q & ws_eret_q & ~ex_final;
        bus_excode   = ex_int ? INT_EXCODE : ws_excode_q;
        bus_badvaddr = ex_int ? 32'h0 : ws_badvaddr_q;
        wb_to_cp0_register_bus = {ex_final, bus_excode, bus_badvaddr, ws_bd_q, ws_pc_q,
                                  mtc0_we, ws_c0_addr_q, ws_c0_wdata_q, eret_flush};
        c0_raddr     = ws_c0_addr_q;
        rf_we        = ws_valid_q & ws_gr_we_q & ~ex_final;
        rf_waddr     = ws_dest_q;
        rf_wdata     = ws_mfc0_q ? c0_rdata : ws_result_q;
        ws_flush     = ex_final | eret_flush;
        ws_flush_pc  = eret_flush ? c0_epc : EX_ENTRY;
    end
endmodule
